alarm_sequencer: RTL and testbench



---
 rtl/alarm_pkg.sv | 17 +
 rtl/key_debounce.sv | 46 ++++
 rtl/alarm_sequencer.sv | 139 +++++++++++++
 tb/tb_alarm_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm ring/snooze/stop sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alarm_pkg;

  // Sequencer states; the 2-bit encoding is fixed so the display side can decode it
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    DONE   = 2'd3
  } alarm_state_t;

  // Tone cadence length: one second of 1 kHz clock cycles
  localparam int CYCLES_PER_SEC = 1000;

endpackage

// File: rtl/key_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, stable-level debounce, rising-edge press pulse.
// Latency: press is high DEB_MS+2 cycles after the raw key rises and stays stable.
// Backpressure: none; press is a one-cycle pulse that is not held for the consumer.
module key_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  localparam logic [4:0] DEB_LAST = 5'(DEB_MS - 1);

  logic       sync_q1;
  logic       sync_q2;
  logic       level;
  logic [4:0] deb_cnt;

  // Synchronize, count consecutive cycles of a differing level, then accept it and pulse on 0->1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      deb_cnt <= 5'd0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 != level) begin
        if (deb_cnt == DEB_LAST) begin
          level   <= sync_q2;
          deb_cnt <= 5'd0;
          press   <= sync_q2;
        end else begin
          deb_cnt <= deb_cnt + 5'd1;
        end
      end else begin
        deb_cnt <= 5'd0;
      end
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze/stop controller with a gated 500 Hz tone on a 1 s on/off cadence.
// Latency: ringing asserts one cycle after arm&&match is seen in IDLE; key actions land DEB_MS+3 cycles after the raw key.
// Backpressure: none; all inputs are levels or one-cycle strobes consumed as they arrive.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int DEB_MS      = 20,
  parameter int BEEP_ON_MS  = 500
) (
  input  logic       _1KHz,
  input  logic       CR,
  input  logic       arm,
  input  logic       match,
  input  logic       sec_tick,
  input  logic       stop_key,
  input  logic       snooze_key,
  output logic       ring,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt,
  output logic       missed
);

  localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
  localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);
  localparam logic [9:0] MS_LAST     = 10'(CYCLES_PER_SEC - 1);
  localparam logic [9:0] BEEP_ON     = 10'(BEEP_ON_MS);
  localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

  alarm_state_t state;
  logic [8:0]   sec_cnt;
  logic [9:0]   ms_cnt;
  logic         stop_press;
  logic         snooze_press;

  key_debounce #(.DEB_MS(DEB_MS)) u_stop_key (
    .clk     (_1KHz),
    .rst     (CR),
    .key_raw (stop_key),
    .press   (stop_press)
  );

  key_debounce #(.DEB_MS(DEB_MS)) u_snooze_key (
    .clk     (_1KHz),
    .rst     (CR),
    .key_raw (snooze_key),
    .press   (snooze_press)
  );

  // Sequencer FSM with its second/cadence counters and the registered tone and status outputs
  always_ff @(posedge _1KHz) begin
    if (CR) begin
      state      <= IDLE;
      sec_cnt    <= 9'd0;
      ms_cnt     <= 10'd0;
      snooze_cnt <= 2'd0;
      missed     <= 1'b0;
      ring       <= 1'b0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
    end else begin
      // Tone is silent outside RING; the RING branch overrides this while it stays in RING
      ring <= 1'b0;
      case (state)
        IDLE: begin
          if (stop_press) begin
            missed <= 1'b0;
          end
          // match is only looked at here, so a dropping match cannot end an event in progress
          if (arm && match) begin
            state      <= RING;
            sec_cnt    <= 9'd0;
            ms_cnt     <= 10'd0;
            snooze_cnt <= 2'd0;
            ringing    <= 1'b1;
          end
        end

        RING: begin
          ms_cnt <= (ms_cnt == MS_LAST) ? 10'd0 : ms_cnt + 10'd1;
          ring   <= (ms_cnt < BEEP_ON) ? ~ring : 1'b0;
          if (!arm || stop_press || (snooze_press && (snooze_cnt == SNOOZE_MAX))) begin
            // Exhausted snoozes act exactly like stop; a simultaneous stop wins and consumes nothing
            state   <= DONE;
            ringing <= 1'b0;
            ring    <= 1'b0;
          end else if (snooze_press) begin
            state      <= SNOOZE;
            snooze_cnt <= snooze_cnt + 2'd1;
            sec_cnt    <= 9'd0;
            ringing    <= 1'b0;
            snoozing   <= 1'b1;
            ring       <= 1'b0;
          end else if (sec_tick) begin
            if (sec_cnt == RING_LAST) begin
              state   <= DONE;
              missed  <= 1'b1;
              ringing <= 1'b0;
              ring    <= 1'b0;
            end else begin
              sec_cnt <= sec_cnt + 9'd1;
            end
          end
        end

        SNOOZE: begin
          // Further snooze presses are deliberately ignored while already snoozing
          if (!arm || stop_press) begin
            state    <= DONE;
            snoozing <= 1'b0;
          end else if (sec_tick) begin
            if (sec_cnt == SNOOZE_LAST) begin
              state    <= RING;
              sec_cnt  <= 9'd0;
              ms_cnt   <= 10'd0;
              snoozing <= 1'b0;
              ringing  <= 1'b1;
            end else begin
              sec_cnt <= sec_cnt + 9'd1;
            end
          end
        end

        DONE: begin
          // Hold off until the matching minute is over so the same minute cannot re-trigger
          if (!match) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer with shortened timing parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       CR = 1'b1;
  logic       arm = 1'b0;
  logic       match = 1'b0;
  logic       sec_tick = 1'b0;
  logic       stop_key = 1'b0;
  logic       snooze_key = 1'b0;
  logic       ring;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_cnt;
  logic       missed;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit tick_en = 1'b0;
  int snz_ticks = 0;
  int ring_ticks = 0;

  typedef struct packed {
    logic       a;
    logic       m;
    logic       st;
    logic       sn;
    logic       tk;
    logic [7:0] n;
    logic       er;
    logic       es;
    logic [1:0] ec;
    logic       em;
  } vec_t;

  vec_t vecs[$];

  alarm_sequencer #(
    .RING_SECS   (4),
    .SNOOZE_SECS (3),
    .MAX_SNOOZE  (3),
    .DEB_MS      (2),
    .BEEP_ON_MS  (500)
  ) dut (
    ._1KHz      (clk),
    .CR         (CR),
    .arm        (arm),
    .match      (match),
    .sec_tick   (sec_tick),
    .stop_key   (stop_key),
    .snooze_key (snooze_key),
    .ring       (ring),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt),
    .missed     (missed)
  );

  initial forever #5 clk = ~clk;

  function automatic vec_t V(input logic a, input logic m, input logic st, input logic sn,
                             input logic tk, input int n, input logic er, input logic es,
                             input logic [1:0] ec, input logic em);
    vec_t v;
    v.a = a; v.m = m; v.st = st; v.sn = sn; v.tk = tk; v.n = 8'(n);
    v.er = er; v.es = es; v.ec = ec; v.em = em;
    return v;
  endfunction

  // One clock edge; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    logic pt, ps, pr;
    pt = sec_tick;
    ps = snoozing;
    pr = ringing;
    @(posedge clk);
    #1;
    cyc++;
    if (pt && ps) snz_ticks++;
    if (pt && pr) ring_ticks++;
    if (tick_en) sec_tick = (cyc % 10 == 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  initial begin
    // Sequence table: inputs held for n edges, then {ringing,snoozing,snooze_cnt,missed} checked
    vecs.push_back(V(1,0,0,0,0,3, 0,0,0,0)); // 0 idle, no match
    vecs.push_back(V(1,1,0,0,0,1, 1,0,0,0)); // 1 ring
    vecs.push_back(V(1,1,0,1,0,5, 0,1,1,0)); // 2 snooze #1
    vecs.push_back(V(1,1,0,0,0,6, 0,1,1,0));
    vecs.push_back(V(1,1,0,0,1,1, 0,1,1,0)); // 4 tick
    vecs.push_back(V(1,1,0,0,0,2, 0,1,1,0));
    vecs.push_back(V(1,1,0,0,1,1, 0,1,1,0)); // 6 tick
    vecs.push_back(V(1,1,0,0,0,2, 0,1,1,0));
    vecs.push_back(V(1,1,0,0,1,1, 1,0,1,0)); // 8 third tick -> ring
    vecs.push_back(V(1,1,0,1,0,5, 0,1,2,0)); // 9 snooze #2
    vecs.push_back(V(1,1,0,0,0,6, 0,1,2,0));
    vecs.push_back(V(1,1,0,0,1,1, 0,1,2,0));
    vecs.push_back(V(1,1,0,0,0,2, 0,1,2,0));
    vecs.push_back(V(1,1,0,0,1,1, 0,1,2,0));
    vecs.push_back(V(1,1,0,0,0,2, 0,1,2,0));
    vecs.push_back(V(1,1,0,0,1,1, 1,0,2,0)); // 15 -> ring
    vecs.push_back(V(1,1,0,1,0,5, 0,1,3,0)); // 16 snooze #3
    vecs.push_back(V(1,1,0,0,0,6, 0,1,3,0));
    vecs.push_back(V(1,1,0,0,1,1, 0,1,3,0));
    vecs.push_back(V(1,1,0,0,0,2, 0,1,3,0));
    vecs.push_back(V(1,1,0,0,1,1, 0,1,3,0));
    vecs.push_back(V(1,1,0,0,0,2, 0,1,3,0));
    vecs.push_back(V(1,1,0,0,1,1, 1,0,3,0)); // 22 -> ring
    vecs.push_back(V(1,1,0,1,0,5, 0,0,3,0)); // 23 4th snooze acts as stop
    vecs.push_back(V(1,1,0,0,0,10,0,0,3,0)); // 24 no re-ring in same minute
    vecs.push_back(V(1,0,0,0,0,1, 0,0,3,0)); // 25 -> idle, count held
    vecs.push_back(V(1,1,0,0,0,1, 1,0,0,0)); // 26 new event clears count
    vecs.push_back(V(1,1,0,0,1,1, 1,0,0,0)); // 27 ring timeout ticks
    vecs.push_back(V(1,1,0,0,0,2, 1,0,0,0));
    vecs.push_back(V(1,1,0,0,1,1, 1,0,0,0));
    vecs.push_back(V(1,1,0,0,0,2, 1,0,0,0));
    vecs.push_back(V(1,1,0,0,1,1, 1,0,0,0));
    vecs.push_back(V(1,1,0,0,0,2, 1,0,0,0));
    vecs.push_back(V(1,1,0,0,1,1, 0,0,0,1)); // 33 fourth tick -> missed
    vecs.push_back(V(1,1,0,0,0,4, 0,0,0,1));
    vecs.push_back(V(1,0,0,0,0,1, 0,0,0,1)); // 35 -> idle
    vecs.push_back(V(1,0,1,0,0,5, 0,0,0,0)); // 36 stop in idle clears missed
    vecs.push_back(V(1,0,0,0,0,6, 0,0,0,0));
    vecs.push_back(V(1,1,0,0,0,1, 1,0,0,0)); // 38 ring
    vecs.push_back(V(1,1,0,1,0,5, 0,1,1,0));
    vecs.push_back(V(1,1,0,0,0,6, 0,1,1,0));
    vecs.push_back(V(1,1,0,0,1,1, 0,1,1,0));
    vecs.push_back(V(1,1,0,0,0,2, 0,1,1,0));
    vecs.push_back(V(1,1,0,0,1,1, 0,1,1,0));
    vecs.push_back(V(1,1,0,0,0,2, 0,1,1,0));
    vecs.push_back(V(1,1,0,0,1,1, 1,0,1,0)); // 45 -> ring
    vecs.push_back(V(1,1,1,1,0,5, 0,0,1,0)); // 46 stop+snooze together -> done, no snooze used
    vecs.push_back(V(1,0,0,0,0,6, 0,0,1,0));
    vecs.push_back(V(1,1,0,0,0,1, 1,0,0,0)); // 48 ring
    vecs.push_back(V(1,1,0,1,0,5, 0,1,1,0));
    vecs.push_back(V(1,1,0,0,0,6, 0,1,1,0));
    vecs.push_back(V(0,1,0,0,0,1, 0,0,1,0)); // 51 arm drop in snooze -> done
    vecs.push_back(V(1,0,0,0,0,1, 0,0,1,0));
    vecs.push_back(V(1,1,0,0,0,1, 1,0,0,0)); // 53 ring
    vecs.push_back(V(1,1,1,0,0,1, 1,0,0,0)); // 54 one-cycle stop glitch
    vecs.push_back(V(1,1,0,0,0,8, 1,0,0,0)); // 55 still ringing
    vecs.push_back(V(0,1,0,0,0,1, 0,0,0,0)); // 56 arm drop in ring -> done
    vecs.push_back(V(1,0,0,0,0,1, 0,0,0,0));

    // Reset state
    #1;
    steps(2);
    check("rst_ring", 32'(ring), 32'd0);
    check("rst_status", {27'd0, ringing, snoozing, snooze_cnt, missed}, 32'd0);
    CR = 1'b0;

    // Tone cadence: toggles for 500 cycles after entry, silent for 500, then restarts
    arm = 1'b1;
    match = 1'b1;
    step();
    check("entry_ringing", 32'(ringing), 32'd1);
    check("entry_ring", 32'(ring), 32'd0);
    for (int i = 1; i <= 1001; i++) begin
      step();
      check($sformatf("tone%0d", i), 32'(ring), (i == 1001) ? 32'd1 : ((i <= 500) ? 32'(i % 2) : 32'd0));
    end
    stop_key = 1'b1;
    steps(5);
    check("stop_ringing", 32'(ringing), 32'd0);
    check("stop_ring", 32'(ring), 32'd0);
    stop_key = 1'b0;
    match = 1'b0;
    steps(6);

    // Table-driven sequences
    foreach (vecs[k]) begin
      arm        = vecs[k].a;
      match      = vecs[k].m;
      stop_key   = vecs[k].st;
      snooze_key = vecs[k].sn;
      sec_tick   = vecs[k].tk;
      steps(int'(vecs[k].n));
      check($sformatf("vec%0d", k), {27'd0, ringing, snoozing, snooze_cnt, missed},
            {27'd0, vecs[k].er, vecs[k].es, vecs[k].ec, vecs[k].em});
      if (vecs[k].es || !vecs[k].er) check($sformatf("vec%0d_ring", k), 32'(ring), 32'd0);
    end
    arm = 1'b1; match = 1'b0; stop_key = 1'b0; snooze_key = 1'b0; sec_tick = 1'b0;
    steps(2);

    // Free-running tick every 10 cycles: snooze duration and unacknowledged timeout
    tick_en = 1'b1;
    match = 1'b1;
    step();
    check("gen_ringing", 32'(ringing), 32'd1);
    snooze_key = 1'b1;
    steps(5);
    check("gen_snoozing", {30'd0, snoozing, ringing}, 32'd2);
    check("gen_scnt", 32'(snooze_cnt), 32'd1);
    snz_ticks = 0;
    snooze_key = 1'b0;
    begin : wait_ring
      for (int i = 0; i < 100; i++) begin
        if (ringing) disable wait_ring;
        step();
      end
    end
    check("gen_rering", 32'(ringing), 32'd1);
    check("gen_snz_ticks", 32'(snz_ticks), 32'd3);
    ring_ticks = 0;
    begin : wait_timeout
      for (int i = 0; i < 100; i++) begin
        if (!ringing) disable wait_timeout;
        step();
      end
    end
    check("gen_timeout", {30'd0, ringing, missed}, 32'd1);
    check("gen_ring_ticks", 32'(ring_ticks), 32'd4);
    match = 1'b0;
    step();
    match = 1'b1;
    step();
    check("gen_restart", {27'd0, ringing, snoozing, snooze_cnt, missed}, 32'h11);

    // CR mid-RING with a used snooze and sticky missed
    snooze_key = 1'b1;
    steps(5);
    snooze_key = 1'b0;
    begin : wait_ring2
      for (int i = 0; i < 100; i++) begin
        if (ringing) disable wait_ring2;
        step();
      end
    end
    steps(3);
    check("pre_cr", {27'd0, ringing, snoozing, snooze_cnt, missed}, 32'h13);
    CR = 1'b1;
    step();
    check("cr_status", {27'd0, ringing, snoozing, snooze_cnt, missed}, 32'd0);
    check("cr_ring", 32'(ring), 32'd0);
    CR = 1'b0;
    tick_en = 1'b0;
    sec_tick = 1'b0;
    steps(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
